// File: rtl/gpio_rx_framer.sv
// gpio_rx_framer
//   Receives bytes from an asynchronous GPIO pad bus, synchronizes them into
//   i_clk, and parses frames of the form HEADER, LEN, LEN payload bytes,
//   XOR checksum. Payload bytes are forwarded to the digital wrapper as
//   one-cycle valid pulses unless the downstream FIFO is full, in which case
//   they are dropped and counted.
//
// Ports
//   i_clk            main clock (only clock)
//   i_rstn           asynchronous active-low reset
//   pad_data[7:0]    raw pad byte, asynchronous
//   pad_strobe       raw pad strobe, asynchronous; rising edge = new byte
//   rx_enable        receive enable; 0 holds the parser idle, outputs quiet
//   fifo_full        downstream FIFO full; payload bytes are dropped
//   clear_status     synchronous pulse clearing frame_err and drop_count
//   in_GPIO_retimed  forwarded payload byte (holds when not valid)
//   in_GPIO_valid    one-cycle qualifier for in_GPIO_retimed
//   frame_done       one-cycle pulse at the end of every frame
//   frame_err        sticky error flag (checksum, drop or timeout)
//   drop_count[7:0]  saturating count of dropped payload bytes
module gpio_rx_framer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [7:0] pad_data,
  input  logic       pad_strobe,
  input  logic       rx_enable,
  input  logic       fifo_full,
  input  logic       clear_status,
  output logic [7:0] in_GPIO_retimed,
  output logic       in_GPIO_valid,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] drop_count
);

  localparam logic [2:0]  FILL     = 3'(SYNC_STAGES);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHK
  } state_t;

  // ---------------------------------------------------------------------
  // Pad synchronizers and strobe edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] strb_sync;
  logic [7:0]             data_sync [SYNC_STAGES];
  logic                   strb_s;
  logic                   strb_prev;
  logic [2:0]             fill_cnt;
  logic                   armed;
  logic                   byte_event;
  logic [7:0]             byte_val;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      strb_sync <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        data_sync[i] <= '0;
      end
    end else begin
      strb_sync    <= {strb_sync[SYNC_STAGES-2:0], pad_strobe};
      data_sync[0] <= pad_data;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        data_sync[i] <= data_sync[i-1];
      end
    end
  end

  assign strb_s   = strb_sync[SYNC_STAGES-1];
  assign byte_val = data_sync[SYNC_STAGES-1];

  // The chain reads 0 right after reset regardless of the pad. Edges are
  // only accepted once the chain holds real pad samples and the strobe has
  // been seen low, so a strobe already high at reset release is ignored.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      strb_prev <= 1'b0;
      fill_cnt  <= '0;
      armed     <= 1'b0;
    end else begin
      strb_prev <= strb_s;
      if (fill_cnt != FILL) begin
        fill_cnt <= fill_cnt + 3'd1;
      end else if (!strb_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign byte_event = strb_s & ~strb_prev & armed;

  // ---------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [7:0]  remain_q, remain_d;
  logic [7:0]  csum_q, csum_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  retimed_d;
  logic        valid_d;
  logic        done_d;
  logic        err_d;
  logic [7:0]  drop_d;
  logic        err_set;
  logic        drop_inc;
  logic [7:0]  drop_base;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q         <= IDLE;
      remain_q        <= '0;
      csum_q          <= '0;
      tmo_q           <= '0;
      in_GPIO_retimed <= '0;
      in_GPIO_valid   <= 1'b0;
      frame_done      <= 1'b0;
      frame_err       <= 1'b0;
      drop_count      <= '0;
    end else begin
      state_q         <= state_d;
      remain_q        <= remain_d;
      csum_q          <= csum_d;
      tmo_q           <= tmo_d;
      in_GPIO_retimed <= retimed_d;
      in_GPIO_valid   <= valid_d;
      frame_done      <= done_d;
      frame_err       <= err_d;
      drop_count      <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    csum_d    = csum_q;
    tmo_d     = tmo_q;
    retimed_d = in_GPIO_retimed;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    err_set   = 1'b0;
    drop_inc  = 1'b0;

    if (!rx_enable) begin
      state_d = IDLE;
      tmo_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          tmo_d = '0;
          if (byte_event && byte_val == HEADER) begin
            state_d = LEN;
          end
        end
        LEN: begin
          if (byte_event) begin
            remain_d = byte_val;
            csum_d   = byte_val;
            state_d  = (byte_val == 8'd0) ? CHK : PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (byte_event) begin
            csum_d   = csum_q ^ byte_val;
            remain_d = remain_q - 8'd1;
            if (fifo_full) begin
              drop_inc = 1'b1;
              err_set  = 1'b1;
            end else begin
              valid_d   = 1'b1;
              retimed_d = byte_val;
            end
            if (remain_q == 8'd1) begin
              state_d = CHK;
            end
          end
        end
        CHK: begin
          if (byte_event) begin
            if (byte_val != csum_q) begin
              err_set = 1'b1;
            end
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      // Inter-byte watchdog, shared by every in-frame state. A byte event
      // always restarts it, so it never competes with the handlers above.
      if (state_q != IDLE) begin
        if (byte_event) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          err_set = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
    end

    // A new error or drop in the same cycle as clear_status takes priority.
    err_d     = err_set ? 1'b1 : (clear_status ? 1'b0 : frame_err);
    drop_base = clear_status ? 8'd0 : drop_count;
    drop_d    = (drop_inc && drop_base != 8'hFF) ? drop_base + 8'd1 : drop_base;
  end

endmodule

// File: tb/tb_gpio_rx_framer.sv
module tb_gpio_rx_framer;

  localparam int unsigned SS   = 2;
  localparam int unsigned TMO  = 40;
  localparam int unsigned HOLD = SS + 2;

  logic       clk;
  logic       rstn;
  logic [7:0] pad_data;
  logic       pad_strobe;
  logic       rx_enable;
  logic       fifo_full;
  logic       clear_status;
  logic [7:0] in_GPIO_retimed;
  logic       in_GPIO_valid;
  logic       frame_done;
  logic       frame_err;
  logic [7:0] drop_count;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int done_cnt   = 0;
  int last_valid_cyc = 0;
  int last_done_cyc  = 0;
  logic [7:0] exp_q [$];

  gpio_rx_framer #(
    .SYNC_STAGES(SS),
    .HEADER(8'hA5),
    .TIMEOUT(TMO)
  ) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .pad_data(pad_data),
    .pad_strobe(pad_strobe),
    .rx_enable(rx_enable),
    .fifo_full(fifo_full),
    .clear_status(clear_status),
    .in_GPIO_retimed(in_GPIO_retimed),
    .in_GPIO_valid(in_GPIO_valid),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every valid pulse.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (in_GPIO_valid === 1'b1) begin
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) chk("valid_without_expect", 16'(exp_q.size()), 16'd1);
        else                   chk("payload", {8'h00, in_GPIO_retimed}, {8'h00, exp_q.pop_front()});
      end
      if (frame_done === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    pad_data = b;
    repeat (HOLD) @(posedge clk);
    #1 pad_strobe = 1'b1;
    repeat (HOLD) @(posedge clk);
    #1 pad_strobe = 1'b0;
    repeat (HOLD) @(posedge clk);
    #1;
  endtask

  task automatic send_frame4(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_status = 1'b1;
    @(posedge clk); #1 clear_status = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  int d0;
  int waited;

  initial begin
    rstn = 1'b0; pad_data = '0; pad_strobe = 1'b0; rx_enable = 1'b1;
    fifo_full = 1'b0; clear_status = 1'b0;
    #1;
    chk("rst_retimed", {8'h00, in_GPIO_retimed}, 16'h0000);
    chk("rst_valid",   {15'd0, in_GPIO_valid}, 16'd0);
    chk("rst_done",    {15'd0, frame_done}, 16'd0);
    chk("rst_err",     {15'd0, frame_err}, 16'd0);
    chk("rst_drop",    {8'h00, drop_count}, 16'h0000);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Good frame, checksum 03^11^22^33 = 03
    d0 = done_cnt;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h03);
    settle();
    chk("good_drained", 16'(exp_q.size()), 16'd0);
    chk("good_done",    16'(done_cnt - d0), 16'd1);
    chk("good_err",     {15'd0, frame_err}, 16'd0);
    chk("hold_retimed", {8'h00, in_GPIO_retimed}, 16'h0033);

    // Bad checksum, sent back-to-back with the previous frame
    d0 = done_cnt;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h00);
    settle();
    chk("badck_drained", 16'(exp_q.size()), 16'd0);
    chk("badck_done",    16'(done_cnt - d0), 16'd1);
    chk("badck_err",     {15'd0, frame_err}, 16'd1);
    pulse_clear();
    chk("badck_cleared", {15'd0, frame_err}, 16'd0);

    // Drop on the second payload byte
    d0 = done_cnt;
    exp_q.push_back(8'h11); exp_q.push_back(8'h33);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    fifo_full = 1'b1; send_byte(8'h22); fifo_full = 1'b0;
    send_byte(8'h33); send_byte(8'h03);
    settle();
    chk("drop_drained", 16'(exp_q.size()), 16'd0);
    chk("drop_done",    16'(done_cnt - d0), 16'd1);
    chk("drop_count1",  {8'h00, drop_count}, 16'h0001);
    chk("drop_err",     {15'd0, frame_err}, 16'd1);
    pulse_clear();
    chk("drop_cleared", {8'h00, drop_count}, 16'h0000);

    // Timeout after one payload byte
    exp_q.push_back(8'h11);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    d0 = done_cnt;
    waited = 0;
    while (done_cnt == d0 && waited < int'(TMO) + 40) begin
      @(posedge clk); waited++;
    end
    #1;
    chk("tmo_seen",    16'(done_cnt - d0), 16'd1);
    chk("tmo_latency", 16'(last_done_cyc - last_valid_cyc), 16'(TMO));
    chk("tmo_err",     {15'd0, frame_err}, 16'd1);
    pulse_clear();
    d0 = done_cnt;
    exp_q.push_back(8'h44);
    send_frame4(8'hA5, 8'h01, 8'h44, 8'h45);
    settle();
    chk("tmo_next_done", 16'(done_cnt - d0), 16'd1);
    chk("tmo_next_err",  {15'd0, frame_err}, 16'd0);
    chk("tmo_next_drained", 16'(exp_q.size()), 16'd0);

    // Leading junk, then zero-length frame
    d0 = done_cnt;
    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    settle();
    chk("zero_done", 16'(done_cnt - d0), 16'd1);
    chk("zero_err",  {15'd0, frame_err}, 16'd0);

    // Receive disabled: a whole frame is ignored
    rx_enable = 1'b0;
    d0 = done_cnt;
    send_frame4(8'hA5, 8'h01, 8'h55, 8'h54);
    settle();
    chk("dis_done", 16'(done_cnt - d0), 16'd0);
    rx_enable = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    exp_q.push_back(8'h44);
    send_frame4(8'hA5, 8'h01, 8'h44, 8'h45);
    settle();
    chk("reen_done", 16'(done_cnt - d0), 16'd1);
    chk("reen_drained", 16'(exp_q.size()), 16'd0);

    // Reset mid-frame (in CHK with a drop recorded), strobe high at release
    d0 = done_cnt;
    send_byte(8'hA5); send_byte(8'h01);
    fifo_full = 1'b1; send_byte(8'h77); fifo_full = 1'b0;
    chk("pre_rst_drop", {8'h00, drop_count}, 16'h0001);
    rstn = 1'b0; pad_strobe = 1'b1; pad_data = 8'hA5;
    #1;
    chk("midrst_retimed", {8'h00, in_GPIO_retimed}, 16'h0000);
    chk("midrst_err",     {15'd0, frame_err}, 16'd0);
    chk("midrst_drop",    {8'h00, drop_count}, 16'h0000);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1 pad_strobe = 1'b0;
    repeat (HOLD) @(posedge clk);
    #1;
    chk("midrst_no_done", 16'(done_cnt - d0), 16'd0);
    exp_q.push_back(8'h44);
    send_frame4(8'hA5, 8'h01, 8'h44, 8'h45);
    settle();
    chk("postrst_done", 16'(done_cnt - d0), 16'd1);
    chk("postrst_err",  {15'd0, frame_err}, 16'd0);
    chk("postrst_drained", 16'(exp_q.size()), 16'd0);

    // 300 forced drops saturate the counter
    fifo_full = 1'b1;
    send_byte(8'hA5); send_byte(8'hFF);
    for (int i = 0; i < 255; i++) send_byte(8'h00);
    send_byte(8'hFF);
    chk("drop_255", {8'h00, drop_count}, 16'h00FF);
    send_byte(8'hA5); send_byte(8'h2D);
    for (int i = 0; i < 45; i++) send_byte(8'h00);
    send_byte(8'h2D);
    fifo_full = 1'b0;
    settle();
    chk("drop_sat", {8'h00, drop_count}, 16'h00FF);
    chk("drop_sat_err", {15'd0, frame_err}, 16'd1);
    pulse_clear();
    chk("sat_cleared", {8'h00, drop_count}, 16'h0000);
    chk("final_drained", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
